// File: rtl/axi_read_port_arbiter.sv
// Two-port round-robin arbiter in front of a single AXI burst read master.
// Port 0 is the noise-estimation reader, port 1 the Wiener-filter reader.
// Each reader posts a one-cycle start with its burst descriptor. The request
// is held until the arbiter grants the port. The descriptor is then replayed
// to the master as a single start pulse. Read beats are steered to the granted
// reader only, and the port is released on the last beat.
//
// Handshake: a read beat is m_rvalid & m_rready in the same cycle. Beats are
// forwarded combinationally (rdN_rvalid/rdN_rlast/rdN_rdata) only while the
// arbiter is in DATA and the port holds the grant. Beats seen in IDLE or ISSUE
// are discarded.
module axi_read_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  rd0_start,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    input  logic [31:0]           rd0_len,
    input  logic [2:0]            rd0_size,
    input  logic [1:0]            rd0_burst,
    output logic                  rd0_pending,
    output logic                  rd0_rvalid,
    output logic                  rd0_rlast,
    output logic [DATA_WIDTH-1:0] rd0_rdata,
    output logic                  rd0_drop,

    input  logic                  rd1_start,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    input  logic [31:0]           rd1_len,
    input  logic [2:0]            rd1_size,
    input  logic [1:0]            rd1_burst,
    output logic                  rd1_pending,
    output logic                  rd1_rvalid,
    output logic                  rd1_rlast,
    output logic [DATA_WIDTH-1:0] rd1_rdata,
    output logic                  rd1_drop,

    output logic                  m_start_read,
    output logic [ADDR_WIDTH-1:0] m_read_addr,
    output logic [31:0]           m_read_len,
    output logic [2:0]            m_read_size,
    output logic [1:0]            m_read_burst,
    input  logic                  m_rvalid,
    input  logic                  m_rready,
    input  logic                  m_rlast,
    input  logic [DATA_WIDTH-1:0] m_rdata,

    output logic                  grant,
    output logic                  busy,
    output logic                  err_len,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            pending;
    logic                  last_served;
    logic [31:0]           beat_cnt;

    logic [ADDR_WIDTH-1:0] hold_addr  [2];
    logic [31:0]           hold_len   [2];
    logic [2:0]            hold_size  [2];
    logic [1:0]            hold_burst [2];

    logic [1:0]            start_in;
    logic [1:0]            len_zero;
    logic [1:0]            clr;
    logic [1:0]            accept;
    logic [1:0]            reject;
    logic                  beat;
    logic                  in_data;
    logic                  last_beat;
    logic                  pick;

    assign start_in  = {rd1_start, rd0_start};
    assign len_zero  = {rd1_len == 32'd0, rd0_len == 32'd0};
    assign beat      = m_rvalid & m_rready;
    assign in_data   = (state == DATA);
    assign last_beat = in_data & beat & m_rlast;

    // The completing port is released before new starts are evaluated, so a
    // start arriving on its own last beat is accepted rather than dropped.
    assign clr    = last_beat ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept = start_in & ~(pending & ~clr) & ~len_zero;
    assign reject = start_in & ~accept;

    // With both ports waiting the one not served last wins; otherwise the
    // only waiting port wins (pending[1] selects port 1 when it is alone).
    assign pick = (pending == 2'b11) ? ~last_served : pending[1];

    // Request capture: latch descriptors, track pending flags, pulse drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 2'b00;
            rd0_drop   <= 1'b0;
            rd1_drop   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                hold_addr[i]  <= '0;
                hold_len[i]   <= '0;
                hold_size[i]  <= '0;
                hold_burst[i] <= '0;
            end
        end else begin
            pending  <= (pending & ~clr) | accept;
            rd0_drop <= reject[0];
            rd1_drop <= reject[1];
            if (accept[0]) begin
                hold_addr[0]  <= rd0_addr;
                hold_len[0]   <= rd0_len;
                hold_size[0]  <= rd0_size;
                hold_burst[0] <= rd0_burst;
            end
            if (accept[1]) begin
                hold_addr[1]  <= rd1_addr;
                hold_len[1]   <= rd1_len;
                hold_size[1]  <= rd1_size;
                hold_burst[1] <= rd1_burst;
            end
        end
    end

    // Arbitration FSM: grant, issue one start pulse, then count beats to rlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_served  <= 1'b1;
            beat_cnt     <= '0;
            m_start_read <= 1'b0;
            m_read_addr  <= '0;
            m_read_len   <= '0;
            m_read_size  <= '0;
            m_read_burst <= '0;
            err_len      <= 1'b0;
        end else begin
            m_start_read <= 1'b0;
            err_len      <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant        <= pick;
                        m_read_addr  <= hold_addr[pick];
                        m_read_len   <= hold_len[pick];
                        m_read_size  <= hold_size[pick];
                        m_read_burst <= hold_burst[pick];
                        m_start_read <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (m_rlast) begin
                            last_served <= grant;
                            err_len     <= (beat_cnt + 32'd1) != m_read_len;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign dbg_state   = state;
    assign rd0_pending = pending[0];
    assign rd1_pending = pending[1];

    assign rd0_rdata  = m_rdata;
    assign rd1_rdata  = m_rdata;
    assign rd0_rvalid = beat & in_data & ~grant;
    assign rd1_rvalid = beat & in_data & grant;
    assign rd0_rlast  = rd0_rvalid & m_rlast;
    assign rd1_rlast  = rd1_rvalid & m_rlast;

endmodule

// File: tb/tb_axi_read_port_arbiter.sv
// Testbench for axi_read_port_arbiter: directed vector table, fairness
// sequence with back-to-back re-requests, then randomized traffic against a
// transaction-level reference model.
module tb_axi_read_port_arbiter;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        rd0_start, rd1_start;
    logic [31:0] rd0_addr, rd1_addr, rd0_len, rd1_len;
    logic [2:0]  rd0_size, rd1_size;
    logic [1:0]  rd0_burst, rd1_burst;
    logic        rd0_pending, rd1_pending, rd0_rvalid, rd1_rvalid;
    logic        rd0_rlast, rd1_rlast, rd0_drop, rd1_drop;
    logic [31:0] rd0_rdata, rd1_rdata;
    logic        m_start_read;
    logic [31:0] m_read_addr, m_read_len;
    logic [2:0]  m_read_size;
    logic [1:0]  m_read_burst;
    logic        m_rvalid, m_rready, m_rlast;
    logic [31:0] m_rdata;
    logic        grant, busy, err_len;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    axi_read_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rd0_start(rd0_start), .rd0_addr(rd0_addr), .rd0_len(rd0_len),
        .rd0_size(rd0_size), .rd0_burst(rd0_burst), .rd0_pending(rd0_pending),
        .rd0_rvalid(rd0_rvalid), .rd0_rlast(rd0_rlast), .rd0_rdata(rd0_rdata),
        .rd0_drop(rd0_drop),
        .rd1_start(rd1_start), .rd1_addr(rd1_addr), .rd1_len(rd1_len),
        .rd1_size(rd1_size), .rd1_burst(rd1_burst), .rd1_pending(rd1_pending),
        .rd1_rvalid(rd1_rvalid), .rd1_rlast(rd1_rlast), .rd1_rdata(rd1_rdata),
        .rd1_drop(rd1_drop),
        .m_start_read(m_start_read), .m_read_addr(m_read_addr),
        .m_read_len(m_read_len), .m_read_size(m_read_size),
        .m_read_burst(m_read_burst), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rlast(m_rlast), .m_rdata(m_rdata),
        .grant(grant), .busy(busy), .err_len(err_len), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rd0_start = 1'b0; rd0_addr = '0; rd0_len = '0; rd0_size = '0; rd0_burst = '0;
        rd1_start = 1'b0; rd1_addr = '0; rd1_len = '0; rd1_size = '0; rd1_burst = '0;
        m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    endtask

    // Ends just after the last reset edge with rst low: DUT is in reset state.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Wait for a grant of 'port', check latency and descriptor, then play
    // 'len' beats. On the last beat the completing port re-requests (len 4).
    task automatic serve(input int port, input logic [31:0] addr, input logic [31:0] len);
        int n;
        logic [31:0] d;
        n = 0;
        @(negedge clk);
        while (!m_start_read && n < 10) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        chk32("fair_start_wait", n, 32'd1);
        chk1("fair_grant", grant, port[0]);
        chk32("fair_addr", m_read_addr, addr);
        chk32("fair_len", m_read_len, len);
        @(posedge clk); #1;
        for (int b = 0; b < int'(len); b++) begin
            d = $urandom;
            m_rvalid = 1'b1; m_rready = 1'b1; m_rdata = d;
            m_rlast = (b == int'(len) - 1);
            if (b == int'(len) - 1) begin
                if (port == 0) begin rd0_start = 1'b1; rd0_addr = 32'h0;  rd0_len = 32'd4; end
                else           begin rd1_start = 1'b1; rd1_addr = 32'h40; rd1_len = 32'd4; end
            end
            @(negedge clk);
            chk1("fair_rvalid0", rd0_rvalid, port == 0);
            chk1("fair_rvalid1", rd1_rvalid, port == 1);
            chk32("fair_rdata", (port == 0) ? rd0_rdata : rd1_rdata, d);
            chk1("fair_rlast", (port == 0) ? rd0_rlast : rd1_rlast, b == int'(len) - 1);
            @(posedge clk); #1;
            rd0_start = 1'b0; rd1_start = 1'b0;
            m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0;
        end
    endtask

    // ---------------- directed vector table ----------------
    // ib = {rst, s0, s1, rv, rr, rl}
    // eb = {st, busy, grant | v0, v1 | rl0, rl1 | p0, p1 | d0, d1 | err_len}
    typedef struct {
        logic [5:0]  ib;
        logic [31:0] a0, l0, a1, l1;
        logic [11:0] eb;
        logic [31:0] ma, ml;
    } vec_t;

    localparam int NV = 28;
    vec_t vt[NV];

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } desc_t;

    initial begin
        desc_t       md[2];
        desc_t       nd[2];
        desc_t       mm;
        bit          mp[2];
        bit          st_in[2];
        bit          edrop[2];
        bit          eerr, indata, bt, ev0, ev1;
        int          mlast, msv, mstart, w;
        logic [31:0] mcnt;
        logic [31:0] d;

        // single request, len 4, with idle/issue discards
        vt[0]  = '{6'b0_10_000, 32'h0, 32'd4, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd0};
        vt[1]  = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_10_00_0, 32'h0,  32'd0};
        vt[2]  = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b110_00_00_10_00_0, 32'h0,  32'd4};
        vt[3]  = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_00_10_00_0, 32'h0,  32'd4};
        vt[4]  = '{6'b0_00_100, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_00_00_10_00_0, 32'h0,  32'd4};
        vt[5]  = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_00_10_00_0, 32'h0,  32'd4};
        vt[6]  = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_00_10_00_0, 32'h0,  32'd4};
        vt[7]  = '{6'b0_00_111, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_10_10_00_0, 32'h0,  32'd4};
        vt[8]  = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd4};
        // zero-length request is dropped and never issued
        vt[9]  = '{6'b0_10_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd4};
        vt[10] = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_00_10_0, 32'h0,  32'd4};
        vt[11] = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd4};
        // port 0 len 4 ends early on beat 3; port 1 re-start while pending is dropped
        vt[12] = '{6'b0_10_000, 32'h0, 32'd4, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd4};
        vt[13] = '{6'b0_01_000, 32'h0, 32'd0, 32'h40, 32'd8, 12'b000_00_00_10_00_0, 32'h0,  32'd4};
        vt[14] = '{6'b0_01_000, 32'h0, 32'd0, 32'h80, 32'd3, 12'b110_00_00_11_00_0, 32'h0,  32'd4};
        vt[15] = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_00_11_01_0, 32'h0,  32'd4};
        vt[16] = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_00_11_00_0, 32'h0,  32'd4};
        vt[17] = '{6'b0_00_111, 32'h0, 32'd0, 32'h0,  32'd0, 12'b010_10_10_11_00_0, 32'h0,  32'd4};
        vt[18] = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_01_00_1, 32'h0,  32'd4};
        vt[19] = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b111_00_00_01_00_0, 32'h40, 32'd8};
        // two beats of port 1, then reset mid-burst
        vt[20] = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b011_01_00_01_00_0, 32'h40, 32'd8};
        vt[21] = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b011_01_00_01_00_0, 32'h40, 32'd8};
        vt[22] = '{6'b1_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b011_00_00_01_00_0, 32'h40, 32'd8};
        vt[23] = '{6'b0_00_110, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd0};
        vt[24] = '{6'b0_00_111, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_00_00_0, 32'h0,  32'd0};
        vt[25] = '{6'b0_01_000, 32'h0, 32'd0, 32'h40, 32'd2, 12'b000_00_00_00_00_0, 32'h0,  32'd0};
        vt[26] = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b000_00_00_01_00_0, 32'h0,  32'd0};
        vt[27] = '{6'b0_00_000, 32'h0, 32'd0, 32'h0,  32'd0, 12'b111_00_00_01_00_0, 32'h40, 32'd2};

        // ---------- phase 1: vector table ----------
        do_reset();
        for (int i = 0; i < NV; i++) begin
            d = $urandom;
            rst       = vt[i].ib[5];
            rd0_start = vt[i].ib[4]; rd0_addr = vt[i].a0; rd0_len = vt[i].l0;
            rd1_start = vt[i].ib[3]; rd1_addr = vt[i].a1; rd1_len = vt[i].l1;
            m_rvalid  = vt[i].ib[2]; m_rready = vt[i].ib[1]; m_rlast = vt[i].ib[0];
            m_rdata   = d;
            @(negedge clk);
            chk1("vec_start", m_start_read, vt[i].eb[11]);
            chk1("vec_busy", busy, vt[i].eb[10]);
            if (vt[i].eb[10]) chk1("vec_grant", grant, vt[i].eb[9]);
            chk1("vec_rvalid0", rd0_rvalid, vt[i].eb[8]);
            chk1("vec_rvalid1", rd1_rvalid, vt[i].eb[7]);
            chk1("vec_rlast0", rd0_rlast, vt[i].eb[6]);
            chk1("vec_rlast1", rd1_rlast, vt[i].eb[5]);
            chk1("vec_pending0", rd0_pending, vt[i].eb[4]);
            chk1("vec_pending1", rd1_pending, vt[i].eb[3]);
            chk1("vec_drop0", rd0_drop, vt[i].eb[2]);
            chk1("vec_drop1", rd1_drop, vt[i].eb[1]);
            chk1("vec_err_len", err_len, vt[i].eb[0]);
            chk32("vec_m_addr", m_read_addr, vt[i].ma);
            chk32("vec_m_len", m_read_len, vt[i].ml);
            chk32("vec_rdata0", rd0_rdata, d);
            @(posedge clk); #1;
        end

        // ---------- phase 2: contention and fairness ----------
        do_reset();
        rd0_start = 1'b1; rd0_addr = 32'h0;  rd0_len = 32'd8;
        rd1_start = 1'b1; rd1_addr = 32'h40; rd1_len = 32'd8;
        @(posedge clk); #1;
        rd0_start = 1'b0; rd1_start = 1'b0;
        serve(0, 32'h0,  32'd8);
        serve(1, 32'h40, 32'd8);
        serve(0, 32'h0,  32'd4);
        serve(1, 32'h40, 32'd4);

        // ---------- phase 3: randomized traffic vs reference model ----------
        do_reset();
        mp[0] = 0; mp[1] = 0; edrop[0] = 0; edrop[1] = 0; eerr = 0;
        md[0] = '{32'h0, 32'h0, 3'h0, 2'h0}; md[1] = md[0]; mm = md[0];
        mlast = 1; msv = -1; mstart = -10; mcnt = '0;
        for (int k = 0; k < 3000; k++) begin
            indata = (msv >= 0) && (k > mstart);
            for (int n = 0; n < 2; n++) begin
                st_in[n]    = ($urandom_range(0, 9) == 0);
                nd[n].addr  = $urandom;
                nd[n].len   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 5));
                nd[n].size  = 3'($urandom_range(0, 7));
                nd[n].burst = 2'($urandom_range(0, 3));
            end
            rd0_start = st_in[0]; rd0_addr = nd[0].addr; rd0_len = nd[0].len;
            rd0_size = nd[0].size; rd0_burst = nd[0].burst;
            rd1_start = st_in[1]; rd1_addr = nd[1].addr; rd1_len = nd[1].len;
            rd1_size = nd[1].size; rd1_burst = nd[1].burst;
            m_rvalid = ($urandom_range(0, 3) != 0);
            m_rready = ($urandom_range(0, 3) != 0);
            if (indata) m_rlast = ($urandom_range(0, 15) == 0) || (mcnt + 32'd1 == mm.len);
            else        m_rlast = ($urandom_range(0, 1) == 1);
            m_rdata = $urandom;

            @(negedge clk);
            bt  = m_rvalid & m_rready;
            ev0 = bt && indata && (msv == 0);
            ev1 = bt && indata && (msv == 1);
            chk1("rnd_busy", busy, msv >= 0);
            chk1("rnd_start", m_start_read, (msv >= 0) && (k == mstart));
            if (msv >= 0) chk1("rnd_grant", grant, msv == 1);
            chk1("rnd_pending0", rd0_pending, mp[0]);
            chk1("rnd_pending1", rd1_pending, mp[1]);
            chk1("rnd_rvalid0", rd0_rvalid, ev0);
            chk1("rnd_rvalid1", rd1_rvalid, ev1);
            chk1("rnd_rlast0", rd0_rlast, ev0 && m_rlast);
            chk1("rnd_rlast1", rd1_rlast, ev1 && m_rlast);
            chk32("rnd_rdata0", rd0_rdata, m_rdata);
            chk32("rnd_rdata1", rd1_rdata, m_rdata);
            chk1("rnd_drop0", rd0_drop, edrop[0]);
            chk1("rnd_drop1", rd1_drop, edrop[1]);
            chk1("rnd_err_len", err_len, eerr);
            chk32("rnd_m_addr", m_read_addr, mm.addr);
            chk32("rnd_m_len", m_read_len, mm.len);
            chk32("rnd_m_size", {29'd0, m_read_size}, {29'd0, mm.size});
            chk32("rnd_m_burst", {30'd0, m_read_burst}, {30'd0, mm.burst});

            // advance the model to the next cycle
            eerr = 0;
            if (msv < 0) begin
                if (mp[0] || mp[1]) begin
                    w      = (mp[0] && mp[1]) ? (1 - mlast) : (mp[0] ? 0 : 1);
                    msv    = w;
                    mstart = k + 1;
                    mm     = md[w];
                    mcnt   = '0;
                end
            end else if (indata && bt) begin
                if (m_rlast) begin
                    eerr    = (mcnt + 32'd1 != mm.len);
                    mp[msv] = 0;
                    mlast   = msv;
                    msv     = -1;
                end else begin
                    mcnt = mcnt + 32'd1;
                end
            end
            for (int n = 0; n < 2; n++) begin
                edrop[n] = 0;
                if (st_in[n]) begin
                    if (mp[n] || nd[n].len == 32'd0) edrop[n] = 1;
                    else begin
                        mp[n] = 1;
                        md[n] = nd[n];
                    end
                end
            end
            @(posedge clk); #1;
        end

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_read_port_arbiter.md
Name: axi_read_port_arbiter

Overview:
- Shares the single AXI burst read master between two burst readers: port 0 is the noise-estimation memory reader, port 1 is the Wiener-filter memory reader.
- Captures each reader's one-cycle start_read request and its burst descriptor.
- Arbitrates round-robin and replays the winner's descriptor to the AXI master as one start pulse.
- Routes the returning read beats to the granted reader only, and releases the port on the last beat.

Parameters:
- ADDR_WIDTH, 32, address width of descriptors and master read_addr.
- DATA_WIDTH, 32, read data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rdN_start  in  1  one-cycle burst request from reader N (N=0,1).
- rdN_addr  in  ADDR_WIDTH  burst start address, sampled with rdN_start.
- rdN_len  in  32  burst length in beats, sampled with rdN_start.
- rdN_size  in  3  AXI size, sampled with rdN_start.
- rdN_burst  in  2  AXI burst type, sampled with rdN_start.
- rdN_pending  out  1  request N captured or in service.
- rdN_rvalid  out  1  beat valid for reader N.
- rdN_rlast  out  1  last beat for reader N.
- rdN_rdata  out  DATA_WIDTH  beat data for reader N.
- rdN_drop  out  1  one-cycle pulse: request N rejected.
- m_start_read  out  1  one-cycle start to the AXI master.
- m_read_addr  out  ADDR_WIDTH  descriptor field driven to the master.
- m_read_len  out  32  descriptor field driven to the master.
- m_read_size  out  3  descriptor field driven to the master.
- m_read_burst  out  2  descriptor field driven to the master.
- m_rvalid  in  1  read channel valid from the master.
- m_rready  in  1  read channel ready from the master.
- m_rlast  in  1  read channel last from the master.
- m_rdata  in  DATA_WIDTH  read channel data from the master.
- grant  out  1  index of the port being served; valid when busy=1.
- busy  out  1  state is not IDLE.
- err_len  out  1  one-cycle pulse: last-beat count mismatch.

Behaviour:
- Reset: all registered outputs are 0, all pending flags are 0, state = IDLE, last_served = 1 (so port 0 wins the first contest). Reset mid-burst abandons the burst; later master beats are not routed until a new grant.
- Capture: rdN_start=1 while pending N=0 and rdN_len!=0 → the descriptor is latched into holding register N and pending N is set on that edge.
- Rejection: rdN_start while pending N=1 → request ignored and rdN_drop pulses. rdN_len==0 → request ignored, rdN_drop pulses, pending stays 0.
- Same-cycle start and completion: a start in the cycle of port N's own completion beat is accepted (clear first, then set).
- Beat definition: beat = m_rvalid & m_rready.
- FSM state IDLE: if exactly one port is pending, grant it. If both are pending, grant the port != last_served. Latch the winner's descriptor into the m_read_* registers, set grant, then go to ISSUE. No pending ports → stay in IDLE.
- FSM state ISSUE: m_start_read=1 for exactly this one cycle, beat_cnt cleared, then go to DATA.
- FSM state DATA: each beat increments beat_cnt (32 bits). A beat with m_rlast=1 clears pending[grant], sets last_served=grant, then goes to IDLE. On that last beat, err_len pulses if beat_cnt+1 != latched len.
- Latency: rdN_start at cycle t with the port idle → m_start_read high in cycle t+2. After the last beat at cycle u, the next m_start_read is at cycle u+2 at the earliest.
- Routing (combinational):
  - rdN_rdata = m_rdata for both ports.
  - rdN_rvalid = beat & state==DATA & grant==N.
  - rdN_rlast = rdN_rvalid & m_rlast.
  - Beats arriving in IDLE or ISSUE are discarded.
- m_read_* fields hold their value until the next grant.
- pending N stays 1 from capture through the last beat inclusive.
- No preemption: a granted burst always runs to rlast.

Test Plan:
- Single request: after reset, rd0_start with addr=0x0, len=4 → m_start_read at t+2 with m_read_addr=0x0 and m_read_len=4. Four beats route to rd0 only, rd0_rlast on beat 4, rd0_pending falls, busy=0.
- Contention: rd0_start and rd1_start in the same cycle (addrs 0x0 and 0x40, len 8) → port 0 served first, port 1 next with m_read_addr=0x40. rd1 never sees rvalid during the port 0 burst.
- Fairness: port 0 re-requests every time it completes while port 1 stays requesting → grants alternate 0,1,0,1 over 4 bursts.
- Drops: rd1_start while rd1_pending=1 → rd1_drop pulses and the original descriptor is unchanged. rd0_start with len=0 → rd0_drop pulses and no m_start_read.
- Length check: len=4 but m_rlast on beat 3 → err_len pulses once, port released, next grant proceeds.
- Reset mid-burst: rst=1 after beat 2 of 8 → all outputs 0. Further m_rvalid beats yield no rdN_rvalid. New rd1_start after reset gets m_start_read at t+2.
